// File: rtl/fetch_decode_pkg.sv
// Shared types for the fetch/decode stage: uop numbering (shared with the
// micro_control ROM), FSM states, RV32I opcodes and shift-control encodings.
package fetch_decode_pkg;

  typedef enum logic [4:0] {
    UOP_ILLEGAL = 5'd0,
    UOP_LUI, UOP_AUIPC, UOP_JAL, UOP_JALR,
    UOP_BEQ, UOP_BNE, UOP_BLT, UOP_BGE,
    UOP_LW, UOP_SW,
    UOP_ADDI, UOP_SLTI, UOP_XORI, UOP_ORI, UOP_ANDI,
    UOP_SLLI, UOP_SRLI, UOP_SRAI,
    UOP_ADD, UOP_SUB, UOP_SLL, UOP_SLT, UOP_XOR, UOP_OR, UOP_AND, UOP_SRL, UOP_SRA
  } uop_e;

  typedef enum logic [1:0] {
    FD_FETCH     = 2'd0,
    FD_ISSUE     = 2'd1,
    FD_WAIT_DONE = 2'd2,
    FD_TRAP      = 2'd3
  } fd_state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [1:0] SHIFT_NONE = 2'b00;
  localparam logic [1:0] SHIFT_SLL  = 2'b01;
  localparam logic [1:0] SHIFT_SRL  = 2'b10;
  localparam logic [1:0] SHIFT_SRA  = 2'b11;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/fetch_decode_stage_rv32_decoder.sv
// Purely combinational RV32I-subset decoder: one instruction word in,
// uop, register indices, immediate and shift controls out.
module rv32_decoder
  import fetch_decode_pkg::*;
(
  input  logic [31:0] ins,
  output uop_e        uop,
  output logic [4:0]  rd_idx,
  output logic [4:0]  rs1_idx,
  output logic [4:0]  rs2_idx,
  output logic [31:0] imm,
  output logic [1:0]  shift_ctl
);

  logic [6:0]  opc_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  uop_e        uop_s;
  logic        use_rd_s, use_rs1_s, use_rs2_s, legal_s;
  logic [31:0] imm_s;
  logic [1:0]  shift_s;

  assign opc_s = ins[6:0];
  assign f3_s  = ins[14:12];
  assign f7_s  = ins[31:25];

  // Classify the word and pick its immediate format and used register fields.
  always_comb begin
    uop_s     = UOP_ILLEGAL;
    use_rd_s  = 1'b0;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    imm_s     = 32'd0;
    shift_s   = SHIFT_NONE;
    case (opc_s)
      OPC_LUI: begin
        uop_s = UOP_LUI; use_rd_s = 1'b1; imm_s = {ins[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        uop_s = UOP_AUIPC; use_rd_s = 1'b1; imm_s = {ins[31:12], 12'd0};
      end
      OPC_JAL: begin
        uop_s = UOP_JAL; use_rd_s = 1'b1;
        imm_s = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OPC_JALR: begin
        uop_s = (f3_s == 3'b000) ? UOP_JALR : UOP_ILLEGAL;
        use_rd_s = 1'b1; use_rs1_s = 1'b1; imm_s = sext12(ins[31:20]);
      end
      OPC_BRANCH: begin
        case (f3_s)
          3'b000:  uop_s = UOP_BEQ;
          3'b001:  uop_s = UOP_BNE;
          3'b100:  uop_s = UOP_BLT;
          3'b101:  uop_s = UOP_BGE;
          default: uop_s = UOP_ILLEGAL;
        endcase
        use_rs1_s = 1'b1; use_rs2_s = 1'b1;
        imm_s = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OPC_LOAD: begin
        uop_s = (f3_s == 3'b010) ? UOP_LW : UOP_ILLEGAL;
        use_rd_s = 1'b1; use_rs1_s = 1'b1; imm_s = sext12(ins[31:20]);
      end
      OPC_STORE: begin
        uop_s = (f3_s == 3'b010) ? UOP_SW : UOP_ILLEGAL;
        use_rs1_s = 1'b1; use_rs2_s = 1'b1; imm_s = sext12({ins[31:25], ins[11:7]});
      end
      OPC_OPIMM: begin
        use_rd_s = 1'b1; use_rs1_s = 1'b1; imm_s = sext12(ins[31:20]);
        case (f3_s)
          3'b000:  uop_s = UOP_ADDI;
          3'b010:  uop_s = UOP_SLTI;
          3'b100:  uop_s = UOP_XORI;
          3'b110:  uop_s = UOP_ORI;
          3'b111:  uop_s = UOP_ANDI;
          3'b001: begin
            uop_s = (f7_s == F7_BASE) ? UOP_SLLI : UOP_ILLEGAL;
            shift_s = SHIFT_SLL; imm_s = {27'd0, ins[24:20]};
          end
          3'b101: begin
            uop_s = (f7_s == F7_BASE) ? UOP_SRLI : (f7_s == F7_ALT) ? UOP_SRAI : UOP_ILLEGAL;
            shift_s = f7_s[5] ? SHIFT_SRA : SHIFT_SRL; imm_s = {27'd0, ins[24:20]};
          end
          default: uop_s = UOP_ILLEGAL;
        endcase
      end
      OPC_OP: begin
        use_rd_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1;
        case (f3_s)
          3'b000:  uop_s = (f7_s == F7_BASE) ? UOP_ADD : (f7_s == F7_ALT) ? UOP_SUB : UOP_ILLEGAL;
          3'b001: begin
            uop_s = (f7_s == F7_BASE) ? UOP_SLL : UOP_ILLEGAL; shift_s = SHIFT_SLL;
          end
          3'b010:  uop_s = (f7_s == F7_BASE) ? UOP_SLT : UOP_ILLEGAL;
          3'b100:  uop_s = (f7_s == F7_BASE) ? UOP_XOR : UOP_ILLEGAL;
          3'b110:  uop_s = (f7_s == F7_BASE) ? UOP_OR  : UOP_ILLEGAL;
          3'b111:  uop_s = (f7_s == F7_BASE) ? UOP_AND : UOP_ILLEGAL;
          3'b101: begin
            uop_s = (f7_s == F7_BASE) ? UOP_SRL : (f7_s == F7_ALT) ? UOP_SRA : UOP_ILLEGAL;
            shift_s = f7_s[5] ? SHIFT_SRA : SHIFT_SRL;
          end
          default: uop_s = UOP_ILLEGAL;
        endcase
      end
      default: uop_s = UOP_ILLEGAL;
    endcase
  end

  // An illegal word yields an all-zero decode so nothing stale leaks downstream.
  assign legal_s   = (uop_s != UOP_ILLEGAL);
  assign uop       = uop_s;
  assign rd_idx    = (legal_s && use_rd_s)  ? ins[11:7]  : 5'd0;
  assign rs1_idx   = (legal_s && use_rs1_s) ? ins[19:15] : 5'd0;
  assign rs2_idx   = (legal_s && use_rs2_s) ? ins[24:20] : 5'd0;
  assign imm       = legal_s ? imm_s : 32'd0;
  assign shift_ctl = legal_s ? shift_s : SHIFT_NONE;

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch/decode stage: fetches one word, decodes it, issues a one-cycle valid
// pulse, then holds until downstream done and advances the PC.
module fetch_decode_stage
  import fetch_decode_pkg::*;
#(
  parameter int              COLS     = 32,
  parameter logic [COLS-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [COLS-1:0] imem_addr,
  input  logic [COLS-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [4:0]      decode_addr,
  output logic            id_rf_valid_inst,
  output logic [4:0]      rd_index,
  output logic [4:0]      rs1_index,
  output logic [4:0]      rs2_index,
  output logic [COLS-1:0] immediate,
  output logic [COLS-1:0] pc_reg,
  output logic [COLS-1:0] pc_plus4,
  output logic [1:0]      id_rf_shift_controls,
  input  logic            done,
  input  logic            redirect_valid,
  input  logic [COLS-1:0] redirect_pc,
  output logic            illegal_inst,
  output logic [COLS-1:0] instret
);

  fd_state_e       state_q, state_d;
  logic [COLS-1:0] pc_q, pc_d, pc_plus4_q, pc_plus4_d, instret_q, instret_d, imm_q, imm_d;
  logic            req_q, req_d, valid_q, valid_d, illegal_q, illegal_d;
  uop_e            uop_q, uop_d, dec_uop_s;
  logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [4:0]      dec_rd_s, dec_rs1_s, dec_rs2_s;
  logic [1:0]      shift_q, shift_d, dec_shift_s;
  logic [31:0]     dec_imm_s;
  logic            unused_redirect_lsb_s;

  assign unused_redirect_lsb_s = ^redirect_pc[1:0];

  rv32_decoder u_dec (
    .ins       (imem_rdata[31:0]),
    .uop       (dec_uop_s),
    .rd_idx    (dec_rd_s),
    .rs1_idx   (dec_rs1_s),
    .rs2_idx   (dec_rs2_s),
    .imm       (dec_imm_s),
    .shift_ctl (dec_shift_s)
  );

  // Next-state, PC and registered-output computation.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    uop_d     = uop_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    shift_d   = shift_q;
    case (state_q)
      FD_FETCH: begin
        if (req_q && imem_ready) begin
          uop_d   = dec_uop_s;
          rd_d    = dec_rd_s;
          rs1_d   = dec_rs1_s;
          rs2_d   = dec_rs2_s;
          imm_d   = COLS'($signed(dec_imm_s));
          shift_d = dec_shift_s;
          state_d = (dec_uop_s == UOP_ILLEGAL) ? FD_TRAP : FD_ISSUE;
        end else begin
          state_d = FD_FETCH;
        end
      end
      FD_ISSUE: state_d = FD_WAIT_DONE;
      FD_WAIT_DONE: begin
        if (done) begin
          instret_d = instret_q + COLS'(1);
          pc_d      = redirect_valid ? {redirect_pc[COLS-1:2], 2'b00} : pc_plus4_q;
          state_d   = FD_FETCH;
        end else begin
          state_d = FD_WAIT_DONE;
        end
      end
      FD_TRAP: state_d = FD_TRAP;
      default: state_d = FD_TRAP;
    endcase
    pc_plus4_d = pc_d + COLS'(4);
    req_d      = (state_d == FD_FETCH);
    valid_d    = (state_d == FD_ISSUE);
    illegal_d  = (state_d == FD_TRAP);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FD_FETCH;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + COLS'(4);
      instret_q  <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      uop_q      <= UOP_ILLEGAL;
      rd_q       <= 5'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      imm_q      <= '0;
      shift_q    <= SHIFT_NONE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      instret_q  <= instret_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      illegal_q  <= illegal_d;
      uop_q      <= uop_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      imm_q      <= imm_d;
      shift_q    <= shift_d;
    end
  end

  assign imem_req             = req_q;
  assign imem_addr            = pc_q;
  assign pc_reg               = pc_q;
  assign pc_plus4             = pc_plus4_q;
  assign decode_addr          = uop_q;
  assign id_rf_valid_inst     = valid_q;
  assign rd_index             = rd_q;
  assign rs1_index            = rs1_q;
  assign rs2_index            = rs2_q;
  assign immediate            = imm_q;
  assign id_rf_shift_controls = shift_q;
  assign illegal_inst         = illegal_q;
  assign instret              = instret_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: directed instruction words with
// hand-computed decodes, checked by a monitor on each issue pulse.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ready, id_rf_valid_inst, done, redirect_valid, illegal_inst;
  logic [31:0] imem_addr, imem_rdata, immediate, pc_reg, pc_plus4, redirect_pc, instret;
  logic [4:0]  decode_addr, rd_index, rs1_index, rs2_index;
  logic [1:0]  id_rf_shift_controls;

  typedef struct packed {
    logic [4:0]  uop;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [1:0]  sh;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  always #5 clk = ~clk;

  fetch_decode_stage #(.COLS(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .decode_addr(decode_addr),
    .id_rf_valid_inst(id_rf_valid_inst), .rd_index(rd_index), .rs1_index(rs1_index),
    .rs2_index(rs2_index), .immediate(immediate), .pc_reg(pc_reg), .pc_plus4(pc_plus4),
    .id_rf_shift_controls(id_rf_shift_controls), .done(done),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .illegal_inst(illegal_inst), .instret(instret)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] u, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [31:0] im, input logic [1:0] sh,
                              input logic [31:0] pc);
    exp_t e;
    e.uop = u; e.rd = d; e.rs1 = s1; e.rs2 = s2; e.imm = im; e.sh = sh; e.pc = pc;
    return e;
  endfunction

  // Monitor: every issue pulse pops one expected decode and compares it.
  always @(negedge clk) begin
    if (rst === 1'b1 && id_rf_valid_inst === 1'b1) begin
      pulses++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got pulse at pc 0x%08h, expected none", pc_reg);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("decode_addr", 32'(decode_addr), 32'(e.uop));
        chk("rd_index", 32'(rd_index), 32'(e.rd));
        chk("rs1_index", 32'(rs1_index), 32'(e.rs1));
        chk("rs2_index", 32'(rs2_index), 32'(e.rs2));
        chk("immediate", immediate, e.imm);
        chk("shift_controls", 32'(id_rf_shift_controls), 32'(e.sh));
        chk("pc_reg", pc_reg, e.pc);
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
      end
    end
  end

  task automatic check_reset();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_rf_valid_inst), 32'd0);
    chk("rst_illegal", 32'(illegal_inst), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_decode_addr", 32'(decode_addr), 32'd0);
    chk("rst_indices", {17'd0, rd_index, rs1_index, rs2_index}, 32'd0);
    chk("rst_immediate", immediate, 32'd0);
    chk("rst_shift", 32'(id_rf_shift_controls), 32'd0);
    chk("rst_pc_reg", pc_reg, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'd4);
  endtask

  // Present one word in the first cycle the request is seen; ends at the ISSUE cycle.
  task automatic fetch(input logic [31:0] word, input logic [31:0] pc, input exp_t e, input bit legal);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("imem_req_seen", 32'(imem_req), 32'd1);
    chk("imem_addr", imem_addr, pc);
    imem_rdata = word;
    imem_ready = 1'b1;
    if (legal) sb_q.push_back(e);
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
  endtask

  // Hold in WAIT_DONE for some cycles, then retire with optional redirect.
  task automatic retire(input int hold, input bit early, input bit redir, input logic [31:0] rpc,
                        input logic [31:0] next_pc, input logic [31:0] exp_ir, input exp_t e);
    bit stable = 1'b1;
    redirect_valid = redir;
    redirect_pc    = rpc;
    if (early) begin
      done = 1'b1;
      @(negedge clk);
      chk("done_ignored_in_issue", 32'(imem_req), 32'd0);
      @(negedge clk);
    end else begin
      @(negedge clk);
      for (int i = 0; i < hold; i++) begin
        if (decode_addr !== e.uop || rd_index !== e.rd || rs1_index !== e.rs1 ||
            rs2_index !== e.rs2 || immediate !== e.imm || id_rf_shift_controls !== e.sh ||
            pc_reg !== e.pc || id_rf_valid_inst !== 1'b0 || imem_req !== 1'b0)
          stable = 1'b0;
        @(negedge clk);
      end
      if (hold > 0) chk("hold_stable", 32'(stable), 32'd1);
      done = 1'b1;
      @(negedge clk);
    end
    done           = 1'b0;
    redirect_valid = 1'b0;
    chk("next_imem_addr", imem_addr, next_pc);
    chk("next_pc_plus4", pc_plus4, next_pc + 32'd4);
    chk("instret", instret, exp_ir);
  endtask

  initial begin
    exp_t e;
    bit   quiet;
    rst = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    done = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b1;

    // ADDI x1,x0,5 (uop 11); done raised already during ISSUE
    e = mk(5'd11, 5'd1, 5'd0, 5'd0, 32'd5, 2'b00, 32'h0);
    fetch(32'h00500093, 32'h0, e, 1'b1);
    retire(0, 1'b1, 1'b0, 32'h0, 32'h4, 32'd1, e);
    // SUB x3,x1,x2 (uop 20), held 40 cycles
    e = mk(5'd20, 5'd3, 5'd1, 5'd2, 32'd0, 2'b00, 32'h4);
    fetch(32'h402081B3, 32'h4, e, 1'b1);
    retire(40, 1'b0, 1'b0, 32'h0, 32'h8, 32'd2, e);
    // SW x2,8(x1) (uop 10), redirect to 0x103 aligns to 0x100
    e = mk(5'd10, 5'd0, 5'd1, 5'd2, 32'd8, 2'b00, 32'h8);
    fetch(32'h0020A423, 32'h8, e, 1'b1);
    retire(2, 1'b0, 1'b1, 32'h103, 32'h100, 32'd3, e);
    // LUI x5,0x12345 (uop 1)
    e = mk(5'd1, 5'd5, 5'd0, 5'd0, 32'h12345000, 2'b00, 32'h100);
    fetch(32'h123452B7, 32'h100, e, 1'b1);
    retire(1, 1'b0, 1'b0, 32'h0, 32'h104, 32'd4, e);
    // SRAI x4,x1,3 (uop 18), redirect to top of memory
    e = mk(5'd18, 5'd4, 5'd1, 5'd0, 32'd3, 2'b11, 32'h104);
    fetch(32'h4030D213, 32'h104, e, 1'b1);
    retire(3, 1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'd5, e);
    // BNE x1,x2,-8 (uop 6) at 0xFFFFFFFC; sequential PC wraps to 0
    e = mk(5'd6, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 2'b00, 32'hFFFFFFFC);
    fetch(32'hFE209CE3, 32'hFFFFFFFC, e, 1'b1);
    retire(1, 1'b0, 1'b0, 32'h0, 32'h0, 32'd6, e);

    // Illegal word: trap, no pulse, request dropped even with ready held high
    fetch(32'hFFFFFFFF, 32'h0, e, 1'b0);
    imem_ready = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (imem_req !== 1'b0 || id_rf_valid_inst !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    chk("trap_quiet", 32'(quiet), 32'd1);
    chk("illegal_inst", 32'(illegal_inst), 32'd1);
    chk("trap_instret", instret, 32'd6);
    imem_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset();
    rst = 1'b1;

    // ANDI x7,x6,-1 (uop 15), abandoned by reset mid-WAIT_DONE with done high
    e = mk(5'd15, 5'd7, 5'd6, 5'd0, 32'hFFFFFFFF, 2'b00, 32'h0);
    fetch(32'hFFF37393, 32'h0, e, 1'b1);
    repeat (3) @(negedge clk);
    rst  = 1'b0;
    done = 1'b1;
    @(negedge clk);
    check_reset();
    done = 1'b0;
    rst  = 1'b1;

    // Fetch resumes from RESET_PC
    e = mk(5'd11, 5'd1, 5'd0, 5'd0, 32'd5, 2'b00, 32'h0);
    fetch(32'h00500093, 32'h0, e, 1'b1);
    retire(2, 1'b0, 1'b0, 32'h0, 32'h4, 32'd1, e);

    @(negedge clk);
    chk("issue_pulses", 32'(pulses), 32'd8);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1);
  end

endmodule
